// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that lets NCACHE caches share one memory port.
// The current bus owner's snoop_out is broadcast to every other cache.
module mem_bus_arbiter #(
    parameter int NCACHE  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NCACHE-1:0]         c_cs,
    input  logic [NCACHE-1:0]         c_rd,
    input  logic [NCACHE-1:0]         c_wr,
    input  logic [NCACHE-1:0]         c_snoop_out,
    output logic [NCACHE-1:0]         c_ready,
    output logic [NCACHE-1:0]         c_snoop_in,
    output logic [NCACHE-1:0]         gnt,
    input  logic                      mem_ready,
    output logic                      mem_cs,
    output logic                      mem_rd,
    output logic                      mem_wr,
    output logic [$clog2(NCACHE)-1:0] owner,
    output logic                      err
);
    localparam int OW = $clog2(NCACHE);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        MEM     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state_q;
    logic [OW-1:0]     rr_ptr_q;
    logic [OW-1:0]     owner_q;
    logic [CW-1:0]     cnt_q;
    logic [NCACHE-1:0] gnt_q;
    logic [NCACHE-1:0] c_ready_q;
    logic              mem_cs_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic              err_q;

    logic [OW-1:0]     sel_s;
    logic              found_s;
    int                idx_s;
    logic              own_cs_s;
    logic              own_rd_s;
    logic              own_wr_s;

    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] idx);
        if (idx == OW'(NCACHE - 1)) begin
            next_idx = '0;
        end else begin
            next_idx = idx + OW'(1);
        end
    endfunction

    assign own_cs_s = c_cs[owner_q];
    assign own_rd_s = c_rd[owner_q];
    assign own_wr_s = c_wr[owner_q];

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        sel_s   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int i = 0; i < NCACHE; i++) begin
            idx_s = int'(rr_ptr_q) + i;
            if (idx_s >= NCACHE) begin
                idx_s = idx_s - NCACHE;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && c_cs[idx_s]) begin
                found_s = 1'b1;
                sel_s   = OW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Snoop broadcast from the owner to every other cache.
    always_comb begin
        c_snoop_in = '0;
        if (gnt_q != '0) begin
            for (int j = 0; j < NCACHE; j++) begin
                if (OW'(j) != owner_q) begin
                    c_snoop_in[j] = c_snoop_out[owner_q];
                end else begin
                    c_snoop_in[j] = 1'b0;
                end
            end
        end else begin
            c_snoop_in = '0;
        end
    end

    // Bus ownership FSM with registered grant, memory and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            c_ready_q <= '0;
            mem_cs_q  <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            c_ready_q <= '0;
            err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_s) begin
                        gnt_q   <= {{(NCACHE-1){1'b0}}, 1'b1} << sel_s;
                        owner_q <= sel_s;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!own_cs_s) begin
                        gnt_q    <= '0;
                        rr_ptr_q <= next_idx(owner_q);
                        state_q  <= IDLE;
                    end else if (own_rd_s ^ own_wr_s) begin
                        mem_cs_q <= 1'b1;
                        mem_rd_q <= own_rd_s;
                        mem_wr_q <= own_wr_s;
                        cnt_q    <= '0;
                        state_q  <= MEM;
                    end else if (own_rd_s && own_wr_s) begin
                        err_q   <= 1'b1;
                        state_q <= RELEASE;
                    end else begin
                        state_q <= RELEASE;
                    end
                end
                MEM: begin
                    // A dropped request wins over a same-cycle completion.
                    if (!own_cs_s) begin
                        mem_cs_q <= 1'b0;
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        gnt_q    <= '0;
                        rr_ptr_q <= next_idx(owner_q);
                        state_q  <= IDLE;
                    end else if (mem_ready) begin
                        c_ready_q <= gnt_q;
                        mem_cs_q  <= 1'b0;
                        mem_rd_q  <= 1'b0;
                        mem_wr_q  <= 1'b0;
                        state_q   <= RELEASE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_q    <= 1'b1;
                        mem_cs_q <= 1'b0;
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        state_q  <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    if (!own_cs_s) begin
                        gnt_q    <= '0;
                        rr_ptr_q <= next_idx(owner_q);
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    gnt_q    <= '0;
                    mem_cs_q <= 1'b0;
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign c_ready = c_ready_q;
    assign mem_cs  = mem_cs_q;
    assign mem_rd  = mem_rd_q;
    assign mem_wr  = mem_wr_q;
    assign owner   = owner_q;
    assign err     = err_q;

endmodule
